// File: rtl/odd_parity_pkg.sv
// Character set and FSM encoding shared by the odd-parity transmitter and checker,
// so both ends of the link agree on what '0', '1' and the separator look like.
package odd_parity_pkg;

  localparam logic [7:0] CHAR_ZERO = 8'h30;
  localparam logic [7:0] CHAR_ONE  = 8'h31;
  localparam logic [7:0] SEP_CHAR  = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_SEP    = 2'd3
  } state_e;

endpackage

// File: rtl/odd_parity_tx.sv
// Serialises a parallel word into ASCII '0'/'1' characters, MSB first, followed by
// one odd-parity character and one separator character that re-idles the checker.
module odd_parity_tx #(
  parameter int         DATA_W    = 8,
  parameter logic [7:0] CHAR_ZERO = odd_parity_pkg::CHAR_ZERO,
  parameter logic [7:0] CHAR_ONE  = odd_parity_pkg::CHAR_ONE,
  parameter logic [7:0] SEP_CHAR  = odd_parity_pkg::SEP_CHAR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [7:0]        out,
  output logic              out_valid,
  output logic              frame_end
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef odd_parity_pkg::state_e state_e;

  state_e            r_state,     w_state_nxt;
  logic [DATA_W-1:0] r_shift,     w_shift_nxt;
  logic [CNT_W-1:0]  r_count,     w_count_nxt;
  logic              r_parity,    w_parity_nxt;
  logic [7:0]        r_out,       w_out_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_frame_end, w_frame_end_nxt;
  logic              w_accept;

  assign in_ready = (r_state == odd_parity_pkg::ST_IDLE) ||
                    (r_state == odd_parity_pkg::ST_SEP);
  assign w_accept = in_valid && in_ready;

  // Outputs are registered, so the character computed here for the state being
  // entered appears on out at the next edge.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned -- otherwise synthesis infers a latch.
    w_state_nxt     = odd_parity_pkg::ST_IDLE;
    w_shift_nxt     = r_shift;
    w_count_nxt     = r_count;
    w_parity_nxt    = r_parity;
    w_out_nxt       = SEP_CHAR;
    w_out_valid_nxt = 1'b0;
    w_frame_end_nxt = 1'b0;

    unique case (r_state)
      odd_parity_pkg::ST_IDLE,
      odd_parity_pkg::ST_SEP: begin
        if (w_accept) begin
          w_state_nxt     = odd_parity_pkg::ST_DATA;
          w_out_nxt       = in_data[DATA_W-1] ? CHAR_ONE : CHAR_ZERO;
          w_out_valid_nxt = 1'b1;
          w_shift_nxt     = in_data << 1;
          w_count_nxt     = CNT_W'(DATA_W - 1);
          w_parity_nxt    = ~^in_data;
        end
      end
      odd_parity_pkg::ST_DATA: begin
        w_out_valid_nxt = 1'b1;
        if (r_count == '0) begin
          w_state_nxt     = odd_parity_pkg::ST_PARITY;
          w_out_nxt       = r_parity ? CHAR_ONE : CHAR_ZERO;
          w_frame_end_nxt = 1'b1;
        end else begin
          w_state_nxt = odd_parity_pkg::ST_DATA;
          w_out_nxt   = r_shift[DATA_W-1] ? CHAR_ONE : CHAR_ZERO;
          w_shift_nxt = r_shift << 1;
          w_count_nxt = r_count - 1'b1;
        end
      end
      odd_parity_pkg::ST_PARITY: w_state_nxt = odd_parity_pkg::ST_SEP;
      default:                   w_state_nxt = odd_parity_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values; blocking ones would make results order-dependent.
    if (rst) begin
      r_state     <= odd_parity_pkg::ST_IDLE;
      r_shift     <= '0;
      r_count     <= '0;
      r_parity    <= 1'b0;
      r_out       <= SEP_CHAR;
      r_out_valid <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_count     <= w_count_nxt;
      r_parity    <= w_parity_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_frame_end <= w_frame_end_nxt;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign frame_end = r_frame_end;

endmodule

// File: tb/tb_odd_parity_tx.sv
// Directed bench for odd_parity_tx: reset, single frames, back-to-back frames,
// ignored in_valid mid-frame, reset mid-frame and a short random parity sweep.
module tb_odd_parity_tx;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] out;
  logic       out_valid;
  logic       frame_end;

  int n_checks = 0;
  int n_fail   = 0;

  odd_parity_tx #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .frame_end (frame_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_ctl(input string tag, input logic v, input logic fe, input logic rdy);
    check({tag, " out_valid"}, 8'(out_valid), 8'(v));
    check({tag, " frame_end"}, 8'(frame_end), 8'(fe));
    check({tag, " in_ready"},  8'(in_ready),  8'(rdy));
  endtask

  // Sends d and checks the whole frame through the separator. hold keeps in_valid
  // high with next_d for a back-to-back accept; glitch pulses 8'h55 mid-frame.
  task automatic send_frame(input logic [7:0] d, input logic [7:0] pchar,
                            input bit hold, input logic [7:0] next_d, input bit glitch);
    in_valid = 1'b1;
    in_data  = d;
    check("accept in_ready", 8'(in_ready), 8'h01);
    tick();
    if (hold) in_data = next_d;
    else      in_valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      check($sformatf("data %h bit%0d", d, i), out, d[i] ? 8'h31 : 8'h30);
      check_ctl($sformatf("data %h bit%0d", d, i), 1'b1, 1'b0, 1'b0);
      if (glitch && i == 4) begin
        in_valid = 1'b1;
        in_data  = 8'h55;
      end else if (glitch && i == 3) begin
        in_valid = 1'b0;
      end
      tick();
    end
    check($sformatf("parity %h", d), out, pchar);
    check_ctl($sformatf("parity %h", d), 1'b1, 1'b1, 1'b0);
    tick();
    check($sformatf("sep %h", d), out, 8'h00);
    check_ctl($sformatf("sep %h", d), 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    for (int c = 0; c < 3; c++) begin
      tick();
      check("reset out", out, 8'h00);
      check_ctl("reset", 1'b0, 1'b0, 1'b1);
    end
    rst = 1'b0;
    tick();
    check("idle out", out, 8'h00);
    check_ctl("idle", 1'b0, 1'b0, 1'b1);

    send_frame(8'hA5, 8'h31, 1'b0, 8'h00, 1'b0);
    tick();
    check("idle after A5", out, 8'h00);
    check_ctl("idle after A5", 1'b0, 1'b0, 1'b1);

    send_frame(8'h01, 8'h30, 1'b0, 8'h00, 1'b0);
    send_frame(8'h00, 8'h31, 1'b0, 8'h00, 1'b0);
    send_frame(8'hFF, 8'h31, 1'b0, 8'h00, 1'b0);

    // Back-to-back: accept of C3 happens in the separator cycle of 3C.
    send_frame(8'h3C, 8'h31, 1'b1, 8'hC3, 1'b0);
    send_frame(8'hC3, 8'h31, 1'b0, 8'h00, 1'b0);

    send_frame(8'hF0, 8'h31, 1'b0, 8'h00, 1'b1);
    tick();
    check("no 55 frame out", out, 8'h00);
    check_ctl("no 55 frame", 1'b0, 1'b0, 1'b1);

    // Reset while the 4th data character of AA is on the line.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    tick();
    in_valid = 1'b0;
    for (int i = 7; i >= 4; i--) begin
      check($sformatf("abort AA bit%0d", i), out, in_data[i] ? 8'h31 : 8'h30);
      if (i > 4) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort out", out, 8'h00);
    check_ctl("abort", 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("post-abort out", out, 8'h00);
      check_ctl("post-abort", 1'b0, 1'b0, 1'b1);
    end
    send_frame(8'h5A, 8'h31, 1'b0, 8'h00, 1'b0);

    for (int n = 0; n < 20; n++) begin
      logic [7:0] w;
      w = 8'($urandom);
      send_frame(w, ($countones(w) % 2 == 1) ? 8'h30 : 8'h31, 1'b0, 8'h00, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
